// File: rtl/uart_baud_controller.sv
// ---------------------------------------------------------------------------
// uart_baud_controller
//
// Programmable baud-rate generator shared by the UART TX and RX engines.
// A prescaler divides the system clock down to a 16x oversample tick
// (os_tick). The tick is then scheduled per engine:
//   - TX gets one bit tick per OVS oversample ticks.
//   - RX gets a mid-bit sample strobe. The RX start-bit detector can re-phase
//     it with rx_align.
// The divisor can only change while both engines are idle. That way a frame
// in flight never sees a rate change.
//
// Ports
//   clk_in          system clock, rising edge
//   reset_n         asynchronous active-low reset
//   cfg_div         requested divisor (system clocks per oversample tick)
//   cfg_valid       divisor request valid
//   cfg_ready       controller accepts a divisor this cycle
//   cfg_err         one-cycle pulse after a transfer whose divisor was clamped
//   tx_run          TX engine requests bit timing
//   rx_run          RX engine requests sample timing
//   rx_align        one-cycle pulse that restarts the RX phase
//   os_tick         oversample tick, one cycle wide
//   tx_bit_tick     one per OVS os_ticks while tx_run
//   rx_sample_tick  mid-bit sample strobe while rx_run
//   active_div      divisor currently in use
//   busy            controller is in RUN
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// uart_baud_phase
//
// Per-engine oversample phase counter.
//   en_i     engine run request; when it is low the phase is held at zero
//   tick_i   shared oversample tick
//   align_i  force the phase to zero; takes priority over tick_i
//   phase_o  current phase
// ---------------------------------------------------------------------------
module uart_baud_phase #(
    parameter int PH_W = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            en_i,
    input  logic            tick_i,
    input  logic            align_i,
    output logic [PH_W-1:0] phase_o
);

    logic [PH_W-1:0] phase_q, phase_d;

    always_comb begin
        phase_d = phase_q;
        if (!en_i || align_i) begin
            phase_d = '0;
        end else if (tick_i) begin
            phase_d = phase_q + PH_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase_o = phase_q;

endmodule

module uart_baud_controller #(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 326,
    parameter int OVS         = 16
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             cfg_err,
    input  logic             tx_run,
    input  logic             rx_run,
    input  logic             rx_align,
    output logic             os_tick,
    output logic             tx_bit_tick,
    output logic             rx_sample_tick,
    output logic [DIV_W-1:0] active_div,
    output logic             busy
);

    localparam int PH_W = $clog2(OVS);
    // Engine index inside the per-engine arrays.
    localparam int ENG_TX = 0;
    localparam int ENG_RX = 1;
    localparam int NUM_ENG = 2;

    // TX ticks on the last phase of a bit. RX samples halfway through the bit.
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVS - 1);
    localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVS / 2 - 1);

    // The divisor is clamped to at least 2, so div_last never underflows.
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             err_q, err_d;

    logic             run_req;
    logic             cfg_xfer;
    logic [DIV_W-1:0] div_last;

    logic [NUM_ENG-1:0]           eng_en;
    logic [NUM_ENG-1:0]           eng_align;
    logic [NUM_ENG-1:0][PH_W-1:0] eng_phase;

    assign run_req  = tx_run | rx_run;
    assign div_last = div_q - DIV_W'(1);

    // A run request in the same cycle as cfg_valid blocks the transfer.
    assign cfg_ready = (state_q == IDLE) && !run_req;
    assign cfg_xfer  = cfg_valid && cfg_ready;

    // -----------------------------------------------------------------------
    // State / prescaler
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        unique case (state_q)
            IDLE: begin
                presc_d = '0;
                if (run_req) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!run_req) begin
                    state_d = IDLE;
                    presc_d = '0;
                end else if (presc_q == div_last) begin
                    presc_d = '0;
                end else begin
                    presc_d = presc_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                presc_d = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Divisor configuration
    // -----------------------------------------------------------------------
    always_comb begin
        div_d = div_q;
        err_d = 1'b0;
        if (cfg_xfer) begin
            if (cfg_div < DIV_MIN) begin
                div_d = DIV_MIN;
                err_d = 1'b1;
            end else begin
                div_d = cfg_div;
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            presc_q <= '0;
            div_q   <= DIV_W'(DEFAULT_DIV);
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            div_q   <= div_d;
            err_q   <= err_d;
        end
    end

    // os_tick is decoded from registered state only, so it adds no latency.
    assign os_tick = (state_q == RUN) && (presc_q == div_last);

    // -----------------------------------------------------------------------
    // Per-engine phase counters. Dropping an engine's run request holds its
    // phase at zero. That covers the RUN->IDLE clear because both requests
    // are low there. TX has no align source.
    // -----------------------------------------------------------------------
    assign eng_en[ENG_TX]    = tx_run;
    assign eng_en[ENG_RX]    = rx_run;
    assign eng_align[ENG_TX] = 1'b0;
    assign eng_align[ENG_RX] = rx_align;

    for (genvar g = 0; g < NUM_ENG; g++) begin : g_eng
        uart_baud_phase #(
            .PH_W (PH_W)
        ) u_phase (
            .clk_i   (clk_in),
            .rst_ni  (reset_n),
            .en_i    (eng_en[g]),
            .tick_i  (os_tick),
            .align_i (eng_align[g]),
            .phase_o (eng_phase[g])
        );
    end

    assign tx_bit_tick    = os_tick && tx_run && (eng_phase[ENG_TX] == PH_LAST);
    // An align on a tick restarts the bit, so that tick must not sample.
    assign rx_sample_tick = os_tick && rx_run && (eng_phase[ENG_RX] == PH_MID)
                            && !rx_align;

    assign active_div = div_q;
    assign cfg_err    = err_q;
    assign busy       = (state_q == RUN);

endmodule

// File: tb/tb_uart_baud_controller.sv
module tb_uart_baud_controller;

    localparam int DIV_W = 16;

    logic             clk_in = 1'b0;
    logic             reset_n;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_valid;
    logic             cfg_ready;
    logic             cfg_err;
    logic             tx_run;
    logic             rx_run;
    logic             rx_align;
    logic             os_tick;
    logic             tx_bit_tick;
    logic             rx_sample_tick;
    logic [DIV_W-1:0] active_div;
    logic             busy;

    int n_vec = 0;
    int n_err = 0;

    uart_baud_controller #(.DIV_W(DIV_W), .DEFAULT_DIV(326), .OVS(16)) dut (
        .clk_in         (clk_in),
        .reset_n        (reset_n),
        .cfg_div        (cfg_div),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_err        (cfg_err),
        .tx_run         (tx_run),
        .rx_run         (rx_run),
        .rx_align       (rx_align),
        .os_tick        (os_tick),
        .tx_bit_tick    (tx_bit_tick),
        .rx_sample_tick (rx_sample_tick),
        .active_div     (active_div),
        .busy           (busy)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. It tracks cycles spent in RUN and oversample ticks
    // seen per engine, and derives every output from those counts with
    // modulo arithmetic.
    // ------------------------------------------------------------------
    bit m_run = 1'b0;
    int m_t   = 0;     // cycles since the RUN-entry edge
    int m_div = 326;
    bit m_err = 1'b0;
    int m_txc = 0;     // os_ticks counted while tx_run
    int m_rxc = 0;     // os_ticks counted since rx start / last align

    logic e_os, e_tx, e_rx, e_ready;

    always_comb begin
        e_ready = !m_run && !(tx_run || rx_run);
        e_os    = m_run && (((m_t + 1) % m_div) == 0);
        e_tx    = e_os && tx_run && ((m_txc % 16) == 15);
        e_rx    = e_os && rx_run && !rx_align && ((m_rxc % 16) == 7);
    end

    always @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            m_run <= 1'b0; m_t <= 0; m_div <= 326; m_err <= 1'b0;
            m_txc <= 0; m_rxc <= 0;
        end else begin
            m_err <= 1'b0;
            if (e_ready && cfg_valid) begin
                m_div <= (int'(cfg_div) < 2) ? 2 : int'(cfg_div);
                m_err <= (int'(cfg_div) < 2);
            end
            if (!m_run) begin
                if (tx_run || rx_run) begin
                    m_run <= 1'b1;
                    m_t   <= 0;
                end
                m_txc <= 0; m_rxc <= 0;
            end else if (!(tx_run || rx_run)) begin
                m_run <= 1'b0; m_txc <= 0; m_rxc <= 0;
            end else begin
                m_t   <= m_t + 1;
                m_txc <= tx_run ? m_txc + (e_os ? 1 : 0) : 0;
                m_rxc <= (!rx_run || rx_align) ? 0 : m_rxc + (e_os ? 1 : 0);
            end
        end
    end

    always @(negedge clk_in) begin
        chk("os_tick",        os_tick,        e_os);
        chk("tx_bit_tick",    tx_bit_tick,    e_tx);
        chk("rx_sample_tick", rx_sample_tick, e_rx);
        chk("cfg_ready",      cfg_ready,      e_ready);
        chk("cfg_err",        cfg_err,        m_err);
        chk("busy",           busy,           m_run);
        chk("active_div",     active_div,     m_div);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // Counts negedges until the selected output is high.
    // sel: 0 = os_tick, 1 = tx_bit_tick.
    task automatic count_until(input int sel, input int maxc, output int n);
        logic s;
        n = 0;
        forever begin
            @(negedge clk_in);
            s = (sel == 0) ? os_tick : tx_bit_tick;
            if (s) return;
            n++;
            if (n > maxc) begin
                n_vec++; n_err++;
                $display("FAIL timeout waiting on output %0d: got none expected within %0d", sel, maxc);
                return;
            end
        end
    endtask

    task automatic load_div(input logic [DIV_W-1:0] d);
        cfg_div = d; cfg_valid = 1'b1;
        step(1);
        cfg_valid = 1'b0;
    endtask

    int n, k;

    initial begin
        reset_n = 1'b0; cfg_div = '0; cfg_valid = 1'b0;
        tx_run = 1'b0; rx_run = 1'b0; rx_align = 1'b0;
        repeat (3) @(posedge clk_in);
        #1 reset_n = 1'b1;

        // Idle after reset.
        chk("rst_active_div", active_div, 326);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_busy", busy, 0);
        step(1000);

        // div=4, TX only.
        load_div(16'd4);
        chk("div4_err", cfg_err, 0);
        chk("div4_active", active_div, 4);
        tx_run = 1'b1;
        count_until(0, 100, n);
        chk("div4_first_os", n, 4);
        step(150);
        tx_run = 1'b0;
        step(3);
        tx_run = 1'b1;
        count_until(1, 200, n);
        chk("div4_first_txbit", n, 64);
        step(150);
        tx_run = 1'b0;
        step(3);

        // RX alignment.
        rx_run = 1'b1;
        step(13);
        for (int i = 0; i < 8 && os_tick; i++) step(1);
        rx_align = 1'b1;
        step(1);
        rx_align = 1'b0;
        k = 0;
        for (int i = 0; i < 200; i++) begin
            if (os_tick) k++;
            if (rx_sample_tick) break;
            step(1);
        end
        chk("rx_align_sample_os", k, 8);
        step(1);
        k = 0;
        for (int i = 0; i < 200; i++) begin
            if (os_tick) begin
                k++;
                if (k == 16) break;
            end
            step(1);
        end
        chk("rx_period_sample", rx_sample_tick, 1);
        rx_align = 1'b1;
        #1;
        chk("rx_align_on_tick_suppress", rx_sample_tick, 0);
        step(1);
        rx_align = 1'b0;
        k = 0;
        for (int i = 0; i < 200; i++) begin
            if (os_tick) k++;
            if (rx_sample_tick) break;
            step(1);
        end
        chk("rx_realign_sample_os", k, 8);
        step(40);
        rx_run = 1'b0;
        step(2);
        rx_align = 1'b1;
        step(1);
        rx_align = 1'b0;
        step(5);

        // Config held while running; run request in the same cycle as valid.
        tx_run = 1'b1; cfg_div = 16'd10; cfg_valid = 1'b1;
        #1;
        chk("run_blocks_ready", cfg_ready, 0);
        step(20);
        chk("held_div_unchanged", active_div, 4);
        chk("held_busy", busy, 1);
        tx_run = 1'b0;
        k = 0;
        for (int i = 0; i < 10 && !cfg_ready; i++) begin
            step(1);
            k++;
        end
        chk("ready_after_idle_steps", k, 1);
        step(1);
        cfg_valid = 1'b0;
        chk("held_transfer_div", active_div, 10);

        // Clamped divisors.
        load_div(16'd1);
        chk("clamp1_err", cfg_err, 1);
        chk("clamp1_div", active_div, 2);
        step(1);
        chk("clamp1_err_drop", cfg_err, 0);
        tx_run = 1'b1;
        count_until(0, 20, n);
        chk("div2_first_os", n, 2);
        step(20);
        tx_run = 1'b0;
        step(3);
        load_div(16'd0);
        chk("clamp0_err", cfg_err, 1);
        chk("clamp0_div", active_div, 2);
        step(1);
        chk("clamp0_err_drop", cfg_err, 0);
        rx_run = 1'b1;
        step(30);
        rx_run = 1'b0;
        step(2);

        // Reset in the middle of a run.
        load_div(16'd10);
        tx_run = 1'b1; rx_run = 1'b1;
        step(37);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_os", os_tick, 0);
        chk("arst_txbit", tx_bit_tick, 0);
        chk("arst_rxs", rx_sample_tick, 0);
        chk("arst_busy", busy, 0);
        chk("arst_div", active_div, 326);
        chk("arst_err", cfg_err, 0);
        repeat (2) @(posedge clk_in);
        #1 reset_n = 1'b1;
        count_until(0, 400, n);
        chk("post_rst_first_os", n, 326);
        step(20);
        tx_run = 1'b0; rx_run = 1'b0;
        step(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
